mem_unit_pingpong: RTL and testbench
====================================

Name: mem_unit_pingpong

Overview:
- Multi-channel, double-buffered IFM memory: next generation of the single-bank dual-port IFM memory unit.
- Holds NUM_CH channel planes of IFM_SIZE x IFM_SIZE words in each of two banks (ping/pong).
- Producer fills one bank through an auto-incrementing write port while the conv engine reads the other bank at random addresses.
- Banks swap by a full/release handshake, so layer N+1 input loads overlap layer N compute.

Parameters:
- DATA_WIDTH, 32, bits per word per channel
- IFM_SIZE, 16, feature-map side; bank depth MEM_SIZE = IFM_SIZE*IFM_SIZE words per channel
- NUM_CH, 3, channels stored side by side, all written and read in lockstep
- ADDRESS_SIZE_IFM, $clog2(IFM_SIZE*IFM_SIZE), address width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- Enable_Write  in  1  write strobe for the current write bank
- Data_Input  in  NUM_CH*DATA_WIDTH  write data; channel c in bits [c*DATA_WIDTH +: DATA_WIDTH]
- Write_Ready  out  1  write bank is not full; writes are accepted
- Address_Read  in  ADDRESS_SIZE_IFM  read address within the current read bank
- Enable_Read  in  1  read strobe
- Read_Done  in  1  single-cycle pulse releasing the current read bank
- Read_Valid  out  1  current read bank is full and readable
- Data_Output  out  NUM_CH*DATA_WIDTH  read data, same packing as Data_Input
- Data_Output_Valid  out  1  Data_Output carries data for an accepted read

Behaviour:
- Always-on clock; one clock domain.
- State: wr_sel, rd_sel (1 bit each); full[1:0]; wr_addr counter (ADDRESS_SIZE_IFM bits).
- Reset values:
  - wr_sel = rd_sel = 0, full = 0, wr_addr = 0
  - Data_Output = 0, Data_Output_Valid = 0
  - Write_Ready = 1, Read_Valid = 0
  - RAM contents are not cleared.
- Write_Ready = !full[wr_sel]; Read_Valid = full[rd_sel]. Both are combinational from registers.
- Accepted write: Enable_Write && Write_Ready.
  - Stores Data_Input to bank wr_sel at wr_addr, all channels.
  - wr_addr then increments.
- On the accepted write with wr_addr == MEM_SIZE-1:
  - full[wr_sel] is set, wr_sel toggles, wr_addr wraps to 0.
  - Effects are visible the next cycle.
- Write with Write_Ready = 0: ignored. No RAM change, wr_addr holds.
- Accepted read: Enable_Read && Read_Valid.
  - Data_Output is registered, 1-cycle latency: data of bank rd_sel at Address_Read appears on the next edge with Data_Output_Valid = 1.
  - Back-to-back reads give one word per cycle.
- Read with Read_Valid = 0: Data_Output_Valid = 0 next cycle; Data_Output holds its previous value.
- Data_Output_Valid deasserts the cycle after the last accepted read; Data_Output holds.
- Address_Read >= MEM_SIZE (non-power-of-two sizes): read data undefined, Data_Output_Valid still asserts. Not checked by the bench.
- Read_Done with Read_Valid = 1: full[rd_sel] is cleared and rd_sel toggles next cycle.
- Read_Done with Read_Valid = 0: ignored.
- Enable_Read and Read_Done in the same cycle: the read is served from the old bank, then the release takes effect.
- Bank completion and Read_Done in the same cycle: both take effect. They always target different banks, because the write bank is never full.
- Both banks full: Write_Ready = 0 until Read_Done.
- Reset mid-fill or mid-read: all state returns to reset values; partially written data is abandoned.
- Each bank/channel is a dual-port array: port A is write-only (producer), port B is read-only (reader). The two banks never share a port in the same cycle.

Optional Feature:
- Macro: MEM_UNIT_PINGPONG_OVF_EN
- Defined:
  - Adds output Overflow (1 bit), reset 0.
  - Overflow is sticky: set on any cycle with Enable_Write && !Write_Ready.
  - Set on any Read_Done or Enable_Read with Read_Valid = 0.
  - Cleared only by reset.
- Undefined: port and logic absent; the illegal events are silently ignored as above.

Test Plan:
All scenarios use IFM_SIZE=4 (MEM_SIZE=16), NUM_CH=2, DATA_WIDTH=8.
- Reset then idle 5 cycles -> Write_Ready=1, Read_Valid=0, Data_Output=0, Data_Output_Valid=0.
- Write 16 words, ch0=i, ch1=0x80+i -> Read_Valid=1 the cycle after the 16th write. Read addresses 0..15 back-to-back -> Data_Output={0x80+a, a} one cycle after each address, Data_Output_Valid=1 for exactly 16 cycles.
- Fill bank0, then bank1 (values 0x40+i), write a 33rd word -> Write_Ready=0, 33rd word dropped. Read address 5 -> 0x05. Read_Done, then read address 5 -> 0x45. Write_Ready=1 again.
- 16th write of bank1 in the same cycle as Read_Done for bank0 -> next cycle full=2'b10, rd_sel=1, wr_sel=0, Read_Valid=1, Write_Ready=1.
- Reset asserted after 7 writes, then 16 writes of 0xAA -> Read_Valid only after the 16th post-reset write; address 0 reads 0xAA.
- With MEM_UNIT_PINGPONG_OVF_EN: Read_Done while Read_Valid=0 -> Overflow=1 next cycle, stays 1 until reset.

Source files
------------

// File: rtl/mem_unit_pingpong.sv
// Double-buffered (ping/pong) multi-channel IFM memory: a producer fills one bank while the reader consumes the other.
// Optional sticky Overflow output is enabled with `define MEM_UNIT_PINGPONG_OVF_EN.
module mem_unit_pingpong #(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 16,
  parameter int NUM_CH           = 3,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         Enable_Write,
  input  logic [NUM_CH*DATA_WIDTH-1:0] Data_Input,
  output logic                         Write_Ready,
  input  logic [ADDRESS_SIZE_IFM-1:0]  Address_Read,
  input  logic                         Enable_Read,
  input  logic                         Read_Done,
  output logic                         Read_Valid,
  output logic [NUM_CH*DATA_WIDTH-1:0] Data_Output,
  output logic                         Data_Output_Valid
`ifdef MEM_UNIT_PINGPONG_OVF_EN
  ,
  output logic                         Overflow
`endif
);

  localparam int MEM_SIZE = IFM_SIZE*IFM_SIZE;
  localparam logic [ADDRESS_SIZE_IFM-1:0] LAST_ADDR = ADDRESS_SIZE_IFM'(MEM_SIZE-1);
  localparam logic [ADDRESS_SIZE_IFM-1:0] ADDR_ONE  = ADDRESS_SIZE_IFM'(1);

  logic                         wr_sel_q, wr_sel_d;
  logic                         rd_sel_q, rd_sel_d;
  logic [1:0]                   full_q, full_d;
  logic [ADDRESS_SIZE_IFM-1:0]  wr_addr_q, wr_addr_d;
  logic [NUM_CH*DATA_WIDTH-1:0] dout_q, dout_d;
  logic                         dout_valid_q, dout_valid_d;

  logic                         wr_fire;
  logic                         rd_fire;
  logic                         release_fire;
  logic                         bank_done;
  logic [NUM_CH*DATA_WIDTH-1:0] rd_word;

  assign Write_Ready       = !full_q[wr_sel_q];
  assign Read_Valid        = full_q[rd_sel_q];
  assign Data_Output       = dout_q;
  assign Data_Output_Valid = dout_valid_q;

  assign wr_fire      = Enable_Write && Write_Ready && !reset;
  assign rd_fire      = Enable_Read && Read_Valid;
  assign release_fire = Read_Done && Read_Valid;
  assign bank_done    = wr_fire && (wr_addr_q == LAST_ADDR);

  // One dual-port array per bank and channel: port A writes, port B reads.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem0 [MEM_SIZE];
    logic [DATA_WIDTH-1:0] mem1 [MEM_SIZE];

    always_ff @(posedge clk) begin
      if (wr_fire && !wr_sel_q) begin
        mem0[wr_addr_q] <= Data_Input[c*DATA_WIDTH +: DATA_WIDTH];
      end
      if (wr_fire && wr_sel_q) begin
        mem1[wr_addr_q] <= Data_Input[c*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign rd_word[c*DATA_WIDTH +: DATA_WIDTH] =
      rd_sel_q ? mem1[Address_Read] : mem0[Address_Read];
  end

  // Completion and release always hit different banks, so both updates can apply.
  always_comb begin
    wr_sel_d     = wr_sel_q;
    rd_sel_d     = rd_sel_q;
    full_d       = full_q;
    wr_addr_d    = wr_addr_q;
    dout_d       = dout_q;
    dout_valid_d = rd_fire;

    if (wr_fire) begin
      wr_addr_d = wr_addr_q + ADDR_ONE;
    end
    if (bank_done) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = !wr_sel_q;
      wr_addr_d        = '0;
    end
    if (release_fire) begin
      full_d[rd_sel_q] = 1'b0;
      rd_sel_d         = !rd_sel_q;
    end
    if (rd_fire) begin
      dout_d = rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_sel_q     <= 1'b0;
      rd_sel_q     <= 1'b0;
      full_q       <= '0;
      wr_addr_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      wr_sel_q     <= wr_sel_d;
      rd_sel_q     <= rd_sel_d;
      full_q       <= full_d;
      wr_addr_q    <= wr_addr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
    end
  end

`ifdef MEM_UNIT_PINGPONG_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if ((Enable_Write && !Write_Ready) || ((Read_Done || Enable_Read) && !Read_Valid)) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_mem_unit_pingpong.sv
// Scoreboard bench for mem_unit_pingpong: a queue-of-full-banks reference model predicts each cycle's outputs.
module tb_mem_unit_pingpong;

  localparam int DW  = 8;
  localparam int IFM = 4;
  localparam int NCH = 2;
  localparam int MEM = IFM*IFM;
  localparam int AW  = 4;
  localparam int WW  = NCH*DW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          Enable_Write = 1'b0;
  logic [WW-1:0] Data_Input = '0;
  logic          Write_Ready;
  logic [AW-1:0] Address_Read = '0;
  logic          Enable_Read = 1'b0;
  logic          Read_Done = 1'b0;
  logic          Read_Valid;
  logic [WW-1:0] Data_Output;
  logic          Data_Output_Valid;
`ifdef MEM_UNIT_PINGPONG_OVF_EN
  logic          Overflow;
`endif

  always #5 clk = ~clk;

  mem_unit_pingpong #(
    .DATA_WIDTH(DW),
    .IFM_SIZE(IFM),
    .NUM_CH(NCH),
    .ADDRESS_SIZE_IFM(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Enable_Write(Enable_Write),
    .Data_Input(Data_Input),
    .Write_Ready(Write_Ready),
    .Address_Read(Address_Read),
    .Enable_Read(Enable_Read),
    .Read_Done(Read_Done),
    .Read_Valid(Read_Valid),
    .Data_Output(Data_Output),
    .Data_Output_Valid(Data_Output_Valid)
`ifdef MEM_UNIT_PINGPONG_OVF_EN
    ,
    .Overflow(Overflow)
`endif
  );

  typedef struct packed {
    logic          dv;
    logic [WW-1:0] d;
    logic          wrdy;
    logic          rvld;
    logic          ovf;
  } exp_t;

  typedef logic [MEM*WW-1:0] img_t;

  exp_t    sb[$];
  img_t    banks[$];
  img_t    fill;
  int      fill_cnt = 0;
  logic [WW-1:0] m_dout = '0;
  logic    m_dv = 1'b0;
  logic    m_ovf = 1'b0;
  int      checks = 0;
  int      errors = 0;

  function automatic void chk(string name, logic [WW-1:0] act, logic [WW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endfunction

  // Drives one cycle, advances the model, and queues the outputs expected after the edge.
  task automatic step(input logic rst, input logic we, input logic [WW-1:0] din,
                      input logic re, input logic [AW-1:0] addr, input logic done);
    exp_t e;
    logic rv;
    logic wr_ok;
    reset        = rst;
    Enable_Write = we;
    Data_Input   = din;
    Enable_Read  = re;
    Address_Read = addr;
    Read_Done    = done;
    if (rst) begin
      banks.delete();
      fill_cnt = 0;
      m_dout   = '0;
      m_dv     = 1'b0;
      m_ovf    = 1'b0;
    end else begin
      rv    = banks.size() > 0;
      wr_ok = banks.size() < 2;
      if ((we && !wr_ok) || ((re || done) && !rv)) m_ovf = 1'b1;
      m_dv = re && rv;
      if (m_dv) m_dout = banks[0][int'(addr)*WW +: WW];
      if (done && rv) void'(banks.pop_front());
      if (we && wr_ok) begin
        fill[fill_cnt*WW +: WW] = din;
        fill_cnt++;
        if (fill_cnt == MEM) begin
          banks.push_back(fill);
          fill_cnt = 0;
        end
      end
    end
    e.dv   = m_dv;
    e.d    = m_dout;
    e.wrdy = banks.size() < 2;
    e.rvld = banks.size() > 0;
    e.ovf  = m_ovf;
    @(posedge clk);
    sb.push_back(e);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic wr(input logic [WW-1:0] din);
    step(1'b0, 1'b1, din, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] addr);
    step(1'b0, 1'b0, '0, 1'b1, addr, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("Data_Output_Valid", WW'(Data_Output_Valid), WW'(e.dv));
        chk("Data_Output", Data_Output, e.d);
        chk("Write_Ready", WW'(Write_Ready), WW'(e.wrdy));
        chk("Read_Valid", WW'(Read_Valid), WW'(e.rvld));
`ifdef MEM_UNIT_PINGPONG_OVF_EN
        chk("Overflow", WW'(Overflow), WW'(e.ovf));
`endif
      end
    end
  end

  initial begin : stim
    logic [AW-1:0] a;
    // Reset then idle
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    idle(5);

    // Single bank fill and back-to-back readback
    for (int i = 0; i < MEM; i++) wr({8'(8'h80 + i), 8'(i)});
    for (int i = 0; i < MEM; i++) rd(AW'(i));
    idle(3);

    // Both banks full, overflow write dropped, release swaps reader
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < MEM; i++) wr({8'(8'h10 + i), 8'(i)});
    for (int i = 0; i < MEM; i++) wr({8'(8'h50 + i), 8'(8'h40 + i)});
    wr(16'hFFFF);
    rd(AW'(5));
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    rd(AW'(5));
    idle(2);

    // Bank completion coincident with release
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < MEM; i++) wr({8'h00, 8'(i)});
    for (int i = 0; i < MEM-1; i++) wr({8'h01, 8'(8'h20 + i)});
    step(1'b0, 1'b1, {8'h01, 8'h2F}, 1'b0, '0, 1'b1);
    rd(AW'(3));
    rd(AW'(15));
    idle(2);

    // Reset mid-fill abandons the partial bank
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 7; i++) wr({8'h33, 8'(i)});
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    for (int i = 0; i < MEM; i++) wr(16'hAAAA);
    rd(AW'(0));
    idle(2);

    // Illegal release with nothing readable
    step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
    idle(3);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      a = AW'($urandom_range(0, MEM-1));
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 6),
           WW'($urandom),
           ($urandom_range(0, 1) == 1),
           a,
           ($urandom_range(0, 19) == 0));
    end
    idle(3);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
